// File: rtl/nv_nvdla_pdp_rdma_dp_in.sv
`default_nettype none
// ============================================================================
//  Module   : nv_nvdla_pdp_rdma_dp_in
//  Brief    : PDP input stage. Takes the RDMA stream into a 2-entry FIFO,
//             tags each atom with line/surface/cube end flags, and counts
//             (and optionally zeroes) fp16 NaN lanes once per layer.
//  Revision : 1.0 - initial release
// ============================================================================
module nv_nvdla_pdp_rdma_dp_in #(
    parameter int DW = 64,
    parameter int IW = 12,
    parameter int CW = 32
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic                 reg2dp_op_en,
    input  logic [1:0]           reg2dp_input_data,
    input  logic                 reg2dp_nan_to_zero,
    input  logic [12:0]          reg2dp_cube_in_width,
    input  logic [12:0]          reg2dp_cube_in_height,
    input  logic [12:0]          reg2dp_cube_in_channel,
    input  logic                 rdma2dp_valid,
    output logic                 rdma2dp_ready,
    input  logic [DW+IW-1:0]     rdma2dp_pd,
    output logic                 dp_valid,
    input  logic                 dp_ready,
    output logic [DW+IW+2:0]     dp_pd,
    output logic [CW-1:0]        dp2reg_nan_input_num,
    output logic                 dp2reg_done,
    output logic                 busy
);

    localparam int c_OW    = DW + IW + 3;
    localparam int c_LANES = DW / 16;
    localparam int c_NW    = $clog2(c_LANES + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_op_en_d;
    logic [12:0]      r_width;
    logic [12:0]      r_height;
    logic [12:0]      r_surf;
    logic             r_fp16;
    logic             r_n2z;
    logic [12:0]      r_w;
    logic [12:0]      r_h;
    logic [12:0]      r_s;
    logic [CW-1:0]    r_nan_cnt;
    logic [c_OW-1:0]  r_mem [0:1];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;

    logic             w_start;
    logic             w_push;
    logic             w_pop;
    logic             w_line_end;
    logic             w_surf_end;
    logic             w_cube_end;
    logic [c_LANES-1:0] w_nan_lane;
    logic [DW-1:0]    w_data_out;
    logic [c_NW-1:0]  w_nan_num;
    logic [CW:0]      w_nan_sum;
    logic             w_fifo_empty_nxt;

    // Start only from IDLE on a fresh 0->1 edge of the layer enable
    assign w_start = (r_state == c_ST_IDLE) && reg2dp_op_en && !r_op_en_d;

    assign rdma2dp_ready = (r_state == c_ST_RUN) && (r_cnt != 2'd2);
    assign w_push        = rdma2dp_valid && rdma2dp_ready;
    assign dp_valid      = (r_cnt != 2'd0);
    assign w_pop         = dp_valid && dp_ready;
    assign dp_pd         = r_mem[r_rptr];

    assign w_line_end = (r_w == r_width);
    assign w_surf_end = w_line_end && (r_h == r_height);
    assign w_cube_end = w_surf_end && (r_s == r_surf);

    // Per-lane NaN detect and optional zeroing (fp16 only)
    for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
        assign w_nan_lane[gi] = r_fp16 &&
                                (rdma2dp_pd[16*gi+10 +: 5] == 5'h1f) &&
                                (rdma2dp_pd[16*gi +: 10] != 10'd0);
        assign w_data_out[16*gi +: 16] = (r_n2z && w_nan_lane[gi]) ? 16'h0000
                                                                   : rdma2dp_pd[16*gi +: 16];
    end

    // Number of NaN lanes in the current input beat
    always_comb begin
        w_nan_num = '0;
        for (int i = 0; i < c_LANES; i++) begin
            w_nan_num = w_nan_num + {{(c_NW-1){1'b0}}, w_nan_lane[i]};
        end
    end

    assign w_nan_sum = {1'b0, r_nan_cnt} + {{(CW+1-c_NW){1'b0}}, w_nan_num};

    // No pushes happen outside RUN, so the post-pop count decides emptiness
    assign w_fifo_empty_nxt = (r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop);

    assign busy                 = (r_state != c_ST_IDLE);
    assign dp2reg_done          = (r_state == c_ST_DONE);
    assign dp2reg_nan_input_num = r_nan_cnt;

    // Layer sequencing: start, last input accepted, FIFO drained, done pulse
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_start) w_state_nxt = c_ST_RUN;
            c_ST_RUN:   if (w_push && w_cube_end) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_fifo_empty_nxt) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register and op_en history
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state   <= c_ST_IDLE;
            r_op_en_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op_en_d <= reg2dp_op_en;
        end
    end

    // Snapshot the layer configuration at start; later register writes are ignored
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_width  <= '0;
            r_height <= '0;
            r_surf   <= '0;
            r_fp16   <= 1'b0;
            r_n2z    <= 1'b0;
        end else if (w_start) begin
            r_width  <= reg2dp_cube_in_width;
            r_height <= reg2dp_cube_in_height;
            r_surf   <= ((reg2dp_input_data == 2'd1) || (reg2dp_input_data == 2'd2))
                        ? (reg2dp_cube_in_channel >> 2) : (reg2dp_cube_in_channel >> 3);
            r_fp16   <= (reg2dp_input_data == 2'd2);
            r_n2z    <= reg2dp_nan_to_zero;
        end
    end

    // Width/height/surface position of the next accepted atom
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || w_start) begin
            r_w <= '0;
            r_h <= '0;
            r_s <= '0;
        end else if (w_push) begin
            if (w_cube_end) begin
                r_w <= '0;
                r_h <= '0;
                r_s <= '0;
            end else if (w_surf_end) begin
                r_w <= '0;
                r_h <= '0;
                r_s <= r_s + 13'd1;
            end else if (w_line_end) begin
                r_w <= '0;
                r_h <= r_h + 13'd1;
            end else begin
                r_w <= r_w + 13'd1;
            end
        end
    end

    // Saturating per-layer NaN lane counter, held after the layer ends
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || w_start) begin
            r_nan_cnt <= '0;
        end else if (w_push) begin
            r_nan_cnt <= w_nan_sum[CW] ? {CW{1'b1}} : w_nan_sum[CW-1:0];
        end
    end

    // Two-entry skid FIFO carrying flags, info and processed data
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {w_cube_end, w_surf_end, w_line_end,
                                  rdma2dp_pd[DW+IW-1:DW], w_data_out};
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire
